// File: rtl/alu_pkg.sv
// Shared opcodes, header length and FSM states for the UART ALU packet engine.
package alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD = 8'hAD;
    localparam logic [7:0] OP_MUL = 8'h88;

    localparam int HDR_LEN_C = 4;

    typedef enum logic [2:0] {
        HDR,
        ECHO,
        ACCUM,
        EMIT,
        DROP
    } state_e;

endpackage

// File: rtl/alu_packet_engine.sv
// Byte-stream packet processor: parses a 4-byte header, then echoes,
// sums or multiplies 32-bit little-endian operands and emits the result.
module alu_packet_engine
    import alu_pkg::*;
#(
    parameter int OPERAND_WIDTH_P = 32,
    parameter int LEN_WIDTH_P = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o
);

    localparam int W = OPERAND_WIDTH_P;
    localparam int L = LEN_WIDTH_P;

    state_e state_q, state_d;

    logic [1:0]   hdr_cnt_q;
    logic [7:0]   opcode_q;
    logic [7:0]   len_lo_q;
    logic [L-1:0] remaining_q;
    logic [1:0]   byte_cnt_q;
    logic [W-1:0] opnd_q;
    logic [W-1:0] acc_q;
    logic         first_q;
    logic [2:0]   emit_idx_q;
    logic [7:0]   tx_data_q;
    logic         tx_valid_q;
    logic         err_q;

    logic         rx_ready;
    logic         rx_fire;
    logic         tx_fire;
    logic         hdr_last;
    logic         last_byte;
    logic         is_echo;
    logic         is_alu;
    logic         bad;
    logic [L-1:0] len_w;
    logic [L-1:0] payload;
    logic [W-1:0] word;

    assign rx_fire = rx_valid_i && rx_ready;
    assign tx_fire = tx_valid_q && tx_ready_i;
    assign hdr_last = rx_fire && (state_q == HDR) && (hdr_cnt_q == 2'd3);
    assign last_byte = rx_fire && (remaining_q == L'(1));
    assign word = {rx_data_i, opnd_q[W-1:8]};

    assign len_w = L'({rx_data_i, len_lo_q});
    assign payload = (len_w < L'(HDR_LEN_C)) ? '0 : len_w - L'(HDR_LEN_C);
    assign is_echo = (opcode_q == OP_ECHO);
    assign is_alu = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
    assign bad = (!is_echo && !is_alu)
               || (len_w < L'(HDR_LEN_C))
               || (is_alu && ((payload == '0) || (payload[1:0] != 2'b00)));

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            HDR, ACCUM, DROP: rx_ready = 1'b1;
            ECHO:             rx_ready = !tx_valid_q || tx_ready_i;
            default:          rx_ready = 1'b0;
        endcase
        if (rst_i) rx_ready = 1'b0;
    end

    // Zero-payload packets (valid or dropped) go straight back to HDR so
    // that DROP/ECHO are only ever entered with bytes still to consume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR: begin
                if (hdr_last) begin
                    if (payload == '0) state_d = HDR;
                    else if (bad) state_d = DROP;
                    else if (is_echo) state_d = ECHO;
                    else state_d = ACCUM;
                end
            end
            ECHO:  if (last_byte) state_d = HDR;
            ACCUM: if (last_byte) state_d = EMIT;
            EMIT:  if (tx_fire && emit_idx_q == 3'd4) state_d = HDR;
            DROP:  if (last_byte) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= HDR;
        else state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hdr_cnt_q   <= '0;
            opcode_q    <= '0;
            len_lo_q    <= '0;
            remaining_q <= '0;
            byte_cnt_q  <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            first_q     <= 1'b0;
            emit_idx_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (tx_fire) tx_valid_q <= 1'b0;
            case (state_q)
                HDR: begin
                    if (rx_fire) begin
                        hdr_cnt_q <= hdr_cnt_q + 2'd1;
                        if (hdr_cnt_q == 2'd0) opcode_q <= rx_data_i;
                        if (hdr_cnt_q == 2'd2) len_lo_q <= rx_data_i;
                        if (hdr_cnt_q == 2'd3) begin
                            remaining_q <= payload;
                            err_q       <= bad;
                            byte_cnt_q  <= '0;
                            first_q     <= 1'b1;
                            emit_idx_q  <= '0;
                        end
                    end
                end
                ECHO: begin
                    if (rx_fire) begin
                        tx_data_q   <= rx_data_i;
                        tx_valid_q  <= 1'b1;
                        remaining_q <= remaining_q - L'(1);
                    end
                end
                ACCUM: begin
                    if (rx_fire) begin
                        opnd_q      <= word;
                        byte_cnt_q  <= byte_cnt_q + 2'd1;
                        remaining_q <= remaining_q - L'(1);
                        if (byte_cnt_q == 2'd3) begin
                            first_q <= 1'b0;
                            if (first_q) acc_q <= word;
                            else if (opcode_q == OP_MUL) acc_q <= acc_q * word;
                            else acc_q <= acc_q + word;
                        end
                    end
                end
                EMIT: begin
                    if ((!tx_valid_q || tx_ready_i) && emit_idx_q != 3'd4) begin
                        tx_data_q  <= acc_q[{emit_idx_q[1:0], 3'b000} +: 8];
                        tx_valid_q <= 1'b1;
                        emit_idx_q <= emit_idx_q + 3'd1;
                    end
                end
                DROP: begin
                    if (rx_fire) remaining_q <= remaining_q - L'(1);
                end
                default: ;
            endcase
        end
    end

    assign rx_ready_o = rx_ready;
    assign tx_data_o = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign err_o = err_q;
    assign busy_o = (state_q != HDR) || (hdr_cnt_q != 2'd0);

endmodule

// File: tb/tb_alu_packet_engine.sv
// Directed bench for alu_packet_engine: echo, add, mul, drops and reset.
module tb_alu_packet_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       err;

    int checks = 0;
    int failures = 0;
    int errcnt = 0;
    logic [7:0] txq[$];

    alu_packet_engine dut (
        .clk_i(clk),
        .rst_i(rst),
        .rx_data_i(rx_data),
        .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready),
        .tx_data_o(tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .busy_o(busy),
        .err_o(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) txq.push_back(tx_data);
            if (err) errcnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check("rx_accept_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_vec(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8]);
    endtask

    task automatic expect_tx(input string tag, input int n,
                             input logic [31:0] exp);
        logic [31:0] got = '0;
        check({tag, "_count"}, txq.size(), n);
        for (int i = 0; i < txq.size() && i < 4; i++)
            got = got | (32'(txq[i]) << (8 * i));
        check(tag, got, exp);
        txq.delete();
    endtask

    initial begin
        logic ok;

        repeat (2) @(negedge clk);
        check("rst_outputs", {rx_ready, tx_valid, tx_data, busy, err}, 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", rx_ready, 1);

        send_vec(128'hEC000400, 4);
        repeat (2) @(negedge clk);
        check("echo_len4_busy", busy, 0);
        check("echo_len4_err", errcnt, 0);
        check("echo_len4_tx", txq.size(), 0);

        send(8'hEC);
        check("busy_mid_hdr", busy, 1);
        send_vec(128'h000700, 3);
        send(8'h41);
        check("echo_lat_41", {tx_valid, tx_data}, 32'h141);
        send(8'h42);
        check("echo_lat_42", {tx_valid, tx_data}, 32'h142);
        send(8'h43);
        check("echo_lat_43", {tx_valid, tx_data}, 32'h143);
        repeat (3) @(negedge clk);
        expect_tx("echo", 3, 32'h00434241);
        check("echo_err", errcnt, 0);

        send_vec(128'hAD000C00_FFFFFFFF_02000000, 12);
        check("add_emit_wait", {rx_ready, tx_valid}, 0);
        @(negedge clk);
        check("add_byte0", {tx_valid, tx_data}, 32'h101);
        repeat (5) @(negedge clk);
        expect_tx("add_wrap", 4, 32'h00000001);
        check("add_idle", busy, 0);

        tx_ready = 1'b0;
        send_vec(128'h88000C00_03000000_05000000, 12);
        @(negedge clk);
        ok = 1'b1;
        repeat (10) begin
            if (!(tx_valid === 1'b1 && tx_data === 8'h0F && rx_ready === 1'b0))
                ok = 1'b0;
            @(negedge clk);
        end
        check("mul_hold", ok, 1);
        tx_ready = 1'b1;
        repeat (6) @(negedge clk);
        expect_tx("mul", 4, 32'h0000000F);

        errcnt = 0;
        send_vec(128'h550006, 3);
        send(8'h00);
        check("err_pulse_hi", err, 1);
        @(negedge clk);
        check("err_pulse_lo", err, 0);
        send_vec(128'hAABB, 2);
        send_vec(128'hEC00050077, 5);
        repeat (3) @(negedge clk);
        expect_tx("echo_after_drop", 1, 32'h00000077);
        check("drop_op_errs", errcnt, 1);

        errcnt = 0;
        send_vec(128'hAD000700_010203, 7);
        repeat (3) @(negedge clk);
        check("badlen_tx", txq.size(), 0);
        check("badlen_errs", errcnt, 1);
        check("badlen_idle", busy, 0);

        send_vec(128'hAD000C00_0102, 6);
        check("accum_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {rx_ready, tx_valid, tx_data, busy, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_vec(128'hAD000C00_05000000_0A000000, 12);
        repeat (6) @(negedge clk);
        expect_tx("add_after_rst", 4, 32'h0000000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
